// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for a shared RV32I multicycle datapath (one ALU, one
//   unified instruction/data memory, one register file). Each instruction
//   walks a 3-5 state sequence. Controls are decoded from the state register,
//   with mem_ready (FETCH, MEMRD, MEMWR) and Zero (BEQ) qualifying the
//   strobes. Memory waits are bounded by a timeout guard.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   op                   opcode from the instruction register
//   Zero                 ALU zero flag
//   mem_ready            current memory access has completed
//   mem_req              memory request, held until mem_ready
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite       datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp         datapath mux selects
//   instr_done           pulse in the retiring state of an instruction
//   illegal_op           pulse in DECODE for an unsupported opcode
//   mem_timeout          sticky memory timeout flag, cleared only by reset
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam bit           TO_EN    = (MEM_TIMEOUT != 0);
  localparam logic [TO_W:0] TO_LIMIT = (TO_W+1)'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10
  } state_t;

  state_t          state_reg, state_next, fsm_next;
  logic [TO_W-1:0] wait_reg, wait_next;
  logic            timeout_reg, timeout_next;

  // raw per-state controls, before reset gating
  logic req_c, irw_c, mw_c, rw_c, pcu_c, branch_c, done_c, ill_c;
  logic waiting, to_fire;
  logic [TO_W:0] wait_inc;

  always_comb begin
    fsm_next  = state_reg;
    req_c     = 1'b0;
    irw_c     = 1'b0;
    mw_c      = 1'b0;
    rw_c      = 1'b0;
    pcu_c     = 1'b0;
    branch_c  = 1'b0;
    done_c    = 1'b0;
    ill_c     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_reg)
      S_FETCH: begin
        req_c     = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          irw_c    = 1'b1;
          pcu_c    = 1'b1;
          fsm_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: fsm_next = S_MEMADR;
          OP_R:         fsm_next = S_EXECR;
          OP_I:         fsm_next = S_EXECI;
          OP_BEQ:       fsm_next = S_BEQ;
          OP_JAL:       fsm_next = S_JAL;
          default: begin
            // PC was already advanced in FETCH, so simply move on
            ill_c    = 1'b1;
            fsm_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        fsm_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        req_c  = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) fsm_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_c      = 1'b1;
        done_c    = 1'b1;
        fsm_next  = S_FETCH;
      end
      S_MEMWR: begin
        // write strobe held for the whole access, not just the ready cycle
        req_c  = 1'b1;
        AdrSrc = 1'b1;
        mw_c   = 1'b1;
        if (mem_ready) begin
          done_c   = 1'b1;
          fsm_next = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b10;
        fsm_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        ALUOp    = 2'b10;
        fsm_next = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c     = 1'b1;
        done_c   = 1'b1;
        fsm_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        branch_c = 1'b1;
        done_c   = 1'b1;
        fsm_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcu_c    = 1'b1;
        fsm_next = S_ALUWB;
      end
      default: fsm_next = S_FETCH;
    endcase
  end

  // Wait counter / timeout guard. The timeout fires on the wait cycle whose
  // increment reaches MEM_TIMEOUT; a cycle with mem_ready=1 never counts, so
  // a ready arriving in that same cycle wins.
  always_comb begin
    waiting  = req_c & ~mem_ready;
    wait_inc = {1'b0, wait_reg} + {{TO_W{1'b0}}, 1'b1};
    to_fire  = TO_EN && waiting && (wait_inc >= TO_LIMIT);

    state_next   = to_fire ? S_FETCH : fsm_next;
    timeout_next = timeout_reg | to_fire;

    wait_next = wait_reg;
    if (to_fire || (state_next != state_reg)) begin
      wait_next = '0;
    end else if (waiting) begin
      wait_next = (wait_inc >= TO_LIMIT) ? TO_LIMIT[TO_W-1:0] : wait_inc[TO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      wait_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Strobes are gated by rst_n so an abort suppresses any write in the
  // very cycle reset is asserted.
  assign mem_req     = req_c & rst_n;
  assign IRWrite     = irw_c & rst_n;
  assign MemWrite    = mw_c & rst_n;
  assign RegWrite    = rw_c & rst_n;
  assign PCWrite     = (pcu_c | (branch_c & Zero)) & rst_n;
  assign instr_done  = done_c & rst_n;
  assign illegal_op  = ill_c & rst_n;
  assign mem_timeout = timeout_reg;

endmodule
